page_order_checker: RTL and testbench

PAGE_ORDER_CHECKER -- requirements
Module: page_order_checker

---
 rtl/page_order_checker.sv | 233 +++++++++++++++++++++++
 tb/tb_page_order_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_order_checker.sv
// Page-ordering rule checker: parses "X|Y" rules then comma-separated update lines,
// scoring middle pages of in-order lines (p1) and of reordered out-of-order lines (p2).
module page_order_checker #(
    parameter int MAX_RULES = 1200,
    parameter int PAGE_W    = 8,
    parameter int MAX_PAGES = 32,
    parameter int SUM_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     read_val,
    input  logic                           read_val_valid,
    output logic                           read_val_ready,
    input  logic                           read_val_done,
    output logic [SUM_W-1:0]               p1_score,
    output logic [SUM_W-1:0]               p2_score,
    output logic                           output_data_valid,
    output logic [$clog2(MAX_RULES+1)-1:0] rule_count,
    output logic [15:0]                    line_count,
    output logic                           overflow,
    output logic [15:0]                    bad_line_count
);

    localparam int RCW = $clog2(MAX_RULES + 1);
    localparam int AW  = (MAX_RULES > 1) ? $clog2(MAX_RULES) : 1;
    localparam int LW  = $clog2(MAX_PAGES + 1);
    localparam int PW  = (MAX_PAGES > 1) ? $clog2(MAX_PAGES) : 1;
    localparam int NPG = 1 << PAGE_W;
    localparam int CW  = 16;
    localparam logic [RCW-1:0] RULE_MAX = RCW'(MAX_RULES);
    localparam logic [LW-1:0]  PAGE_MAX = LW'(MAX_PAGES);

    typedef enum logic [2:0] {RULES, LINES, SCAN, PICK, ACC, DONE} state_t;

    state_t              r_state, w_next;
    logic [PAGE_W-1:0]   r_x, r_y;
    logic                r_in_y, r_any;
    logic [PAGE_W-1:0]   r_mem_x [MAX_RULES];
    logic [PAGE_W-1:0]   r_mem_y [MAX_RULES];
    logic [RCW-1:0]      r_rule_cnt, r_idx;
    logic [PAGE_W-1:0]   r_rx_p1, r_ry_p1;
    logic                r_rvld_p1;
    logic [PAGE_W-1:0]   r_acc;
    logic                r_have;
    logic [PAGE_W-1:0]   r_buf [MAX_PAGES];
    logic [NPG-1:0]      r_present;
    logic [PW-1:0]       r_pos [NPG];
    logic [CW-1:0]       r_bcnt [MAX_PAGES];
    logic [LW-1:0]       r_len, r_cnt;
    logic                r_end_pend, r_done_pend, r_bad, r_broken, r_found;
    logic [PAGE_W-1:0]   r_sel;
    logic [SUM_W-1:0]    r_p1, r_p2;
    logic [15:0]         r_lines, r_bad_cnt;
    logic                r_ovf;

    logic                w_take, w_done, w_dig, w_nl, w_sep, w_bar, w_have_n;
    logic                w_in_lines, w_append, w_push, w_end, w_rule_wr, w_pick_hit;
    logic [PAGE_W-1:0]   w_dval, w_acc_n, w_pick_val;
    logic [LW-1:0]       w_half;
    logic [CW-1:0]       w_half_c;
    logic [PW-1:0]       w_pick_idx, w_mid_idx, w_len_idx;

    assign w_take     = read_val_valid & read_val_ready;
    assign w_done     = read_val_done & read_val_ready;
    assign w_dig      = w_take & (read_val >= 8'h30) & (read_val <= 8'h39);
    assign w_nl       = w_take & (read_val == 8'h0A);
    assign w_sep      = w_take & ((read_val == 8'h2C) | (read_val == 8'h0A));
    assign w_bar      = w_take & (read_val == 8'h7C);
    assign w_dval     = PAGE_W'(read_val[3:0]);
    assign w_acc_n    = w_dig ? (r_acc * PAGE_W'(10) + w_dval) : r_acc;
    assign w_have_n   = r_have | w_dig;
    assign w_in_lines = (r_state == LINES);
    // A done with digits pending closes the page just like a separator would.
    assign w_append   = w_in_lines & w_have_n & (w_sep | w_done);
    assign w_push     = w_append & (r_len != PAGE_MAX) & ~r_present[w_acc_n];
    assign w_end      = w_in_lines & (w_nl | w_done) & (w_have_n | (r_len != '0));
    assign w_rule_wr  = (r_state == RULES) & w_nl & r_in_y & (r_rule_cnt != RULE_MAX);
    assign w_len_idx  = r_len[PW-1:0];
    assign w_half     = r_len >> 1;
    assign w_half_c   = CW'(w_half);
    assign w_mid_idx  = w_half[PW-1:0];
    assign w_pick_idx = r_cnt[PW-1:0];
    assign w_pick_hit = ~r_broken | (r_bcnt[w_pick_idx] == w_half_c);
    assign w_pick_val = r_broken ? r_buf[w_pick_idx] : r_buf[w_mid_idx];

    always_ff @(posedge clk) begin
        if (rst) r_state <= RULES;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RULES: begin
                if (w_done)              w_next = DONE;
                else if (w_nl && !r_any) w_next = LINES;
            end
            LINES: begin
                if (r_end_pend)          w_next = r_bad ? ACC : SCAN;
                else if (!w_end && w_done) w_next = DONE;
            end
            SCAN:    if (r_idx == r_rule_cnt) w_next = PICK;
            PICK:    if (r_cnt == r_len - LW'(1)) w_next = ACC;
            ACC:     w_next = r_done_pend ? DONE : LINES;
            DONE:    w_next = DONE;
            default: w_next = RULES;
        endcase
    end

    always_comb begin
        read_val_ready    = 1'b0;
        output_data_valid = 1'b0;
        case (r_state)
            RULES:   read_val_ready = 1'b1;
            LINES:   read_val_ready = ~r_end_pend;
            DONE:    output_data_valid = 1'b1;
            default: ;
        endcase
    end

    // Storage without reset: rule table, line buffer, page positions, table read stage.
    always_ff @(posedge clk) begin
        if (w_rule_wr) begin
            r_mem_x[r_rule_cnt[AW-1:0]] <= r_x;
            r_mem_y[r_rule_cnt[AW-1:0]] <= r_y;
        end
        if (r_state == SCAN && r_idx < r_rule_cnt) begin
            r_rx_p1 <= r_mem_x[r_idx[AW-1:0]];
            r_ry_p1 <= r_mem_y[r_idx[AW-1:0]];
        end
        if (w_push) begin
            r_buf[w_len_idx] <= w_acc_n;
            r_pos[w_acc_n]   <= w_len_idx;
        end
        if (r_state == PICK && w_pick_hit) r_sel <= w_pick_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0; r_y <= '0; r_in_y <= 1'b0; r_any <= 1'b0;
            r_rule_cnt <= '0; r_idx <= '0; r_rvld_p1 <= 1'b0;
            r_acc <= '0; r_have <= 1'b0; r_present <= '0;
            r_len <= '0; r_cnt <= '0;
            r_end_pend <= 1'b0; r_done_pend <= 1'b0;
            r_bad <= 1'b0; r_broken <= 1'b0; r_found <= 1'b0;
            r_p1 <= '0; r_p2 <= '0; r_lines <= '0; r_bad_cnt <= '0; r_ovf <= 1'b0;
            for (int i = 0; i < MAX_PAGES; i++) r_bcnt[i] <= '0;
        end else begin
            r_rvld_p1 <= (r_state == SCAN) && (r_idx < r_rule_cnt);
            case (r_state)
                RULES: begin
                    if (w_dig) begin
                        if (r_in_y) r_y <= r_y * PAGE_W'(10) + w_dval;
                        else        r_x <= r_x * PAGE_W'(10) + w_dval;
                        r_any <= 1'b1;
                    end
                    if (w_bar) r_in_y <= 1'b1;
                    if (w_nl) begin
                        if (r_in_y) begin
                            if (r_rule_cnt == RULE_MAX) r_ovf <= 1'b1;
                            else                        r_rule_cnt <= r_rule_cnt + RCW'(1);
                        end
                        r_x <= '0; r_y <= '0; r_in_y <= 1'b0; r_any <= 1'b0;
                    end
                end
                LINES: begin
                    if (r_end_pend) begin
                        r_end_pend <= 1'b0;
                        r_idx      <= '0;
                        r_cnt      <= '0;
                    end else begin
                        if (w_dig) begin
                            r_acc  <= w_acc_n;
                            r_have <= 1'b1;
                        end
                        if (w_sep || w_done) begin
                            r_acc  <= '0;
                            r_have <= 1'b0;
                        end
                        if (w_append) begin
                            if (r_len == PAGE_MAX) begin
                                r_bad <= 1'b1;
                                r_ovf <= 1'b1;
                            end else if (r_present[w_acc_n]) begin
                                r_bad <= 1'b1;
                            end else begin
                                r_present[w_acc_n] <= 1'b1;
                                r_len <= r_len + LW'(1);
                            end
                        end
                        if (w_end) begin
                            r_end_pend  <= 1'b1;
                            r_done_pend <= w_done;
                        end
                    end
                end
                // Table read issued here, rule applied one cycle later from the _p1 stage.
                SCAN: begin
                    if (r_idx < r_rule_cnt) r_idx <= r_idx + RCW'(1);
                    if (r_rvld_p1 && r_present[r_rx_p1] && r_present[r_ry_p1]) begin
                        if (r_pos[r_rx_p1] > r_pos[r_ry_p1]) r_broken <= 1'b1;
                        r_bcnt[r_pos[r_ry_p1]] <= r_bcnt[r_pos[r_ry_p1]] + CW'(1);
                    end
                end
                PICK: begin
                    if (w_pick_hit) r_found <= 1'b1;
                    r_cnt <= r_cnt + LW'(1);
                end
                ACC: begin
                    if (r_bad || !r_found) r_bad_cnt <= r_bad_cnt + 16'd1;
                    else if (r_broken)     r_p2 <= r_p2 + SUM_W'(r_sel);
                    else                   r_p1 <= r_p1 + SUM_W'(r_sel);
                    r_lines   <= r_lines + 16'd1;
                    r_present <= '0;
                    r_len     <= '0;
                    r_bad     <= 1'b0;
                    r_broken  <= 1'b0;
                    r_found   <= 1'b0;
                    for (int i = 0; i < MAX_PAGES; i++) r_bcnt[i] <= '0;
                end
                default: ;
            endcase
        end
    end

    assign p1_score       = r_p1;
    assign p2_score       = r_p2;
    assign rule_count     = r_rule_cnt;
    assign line_count     = r_lines;
    assign overflow       = r_ovf;
    assign bad_line_count = r_bad_cnt;

endmodule

// File: tb/tb_page_order_checker.sv
// Bench for page_order_checker: vector table, hand sequences, random streams vs a sort-based model.
module tb_page_order_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] val;
    logic       vld, dn, tsel;

    logic        a_rdy, a_odv, a_ovf, b_rdy, b_odv, b_ovf;
    logic [31:0] a_p1, a_p2, b_p1, b_p2;
    logic [10:0] a_rc;
    logic [1:0]  b_rc;
    logic [15:0] a_lc, a_bad, b_lc, b_bad;

    page_order_checker dut (
        .clk(clk), .rst(rst), .read_val(val),
        .read_val_valid(vld & ~tsel), .read_val_ready(a_rdy), .read_val_done(dn & ~tsel),
        .p1_score(a_p1), .p2_score(a_p2), .output_data_valid(a_odv),
        .rule_count(a_rc), .line_count(a_lc), .overflow(a_ovf), .bad_line_count(a_bad)
    );

    page_order_checker #(.MAX_RULES(2)) dut2 (
        .clk(clk), .rst(rst), .read_val(val),
        .read_val_valid(vld & tsel), .read_val_ready(b_rdy), .read_val_done(dn & tsel),
        .p1_score(b_p1), .p2_score(b_p2), .output_data_valid(b_odv),
        .rule_count(b_rc), .line_count(b_lc), .overflow(b_ovf), .bad_line_count(b_bad)
    );

    wire        rdy = tsel ? b_rdy : a_rdy;
    wire        odv = tsel ? b_odv : a_odv;
    wire        ovf = tsel ? b_ovf : a_ovf;
    wire [31:0] p1  = tsel ? b_p1 : a_p1;
    wire [31:0] p2  = tsel ? b_p2 : a_p2;
    wire [15:0] lc  = tsel ? b_lc : a_lc;
    wire [15:0] bad = tsel ? b_bad : a_bad;
    wire [10:0] rc  = tsel ? {9'd0, b_rc} : a_rc;

    typedef struct {
        string name;
        string stream;
        bit    tgt;
        bit    last_with_done;
        int    p1, p2, rc, lc, bad, ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   bef[256][256];

    string ex_rules = {"47|53\n97|13\n97|61\n97|47\n75|29\n61|13\n75|53\n29|13\n97|29\n53|29\n",
                       "61|53\n97|53\n61|29\n47|13\n75|47\n97|75\n47|61\n75|61\n47|29\n75|13\n53|13\n\n"};
    string ex_lines = {"75,47,61,53,29\n97,61,53,29,13\n75,29,13\n75,97,47,61,53\n",
                       "61,13,29\n97,13,75,29,47\n"};

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input string s, input bit tgt, input bit lwd,
                           input int e1, input int e2, input int erc, input int elc,
                           input int ebad, input int eovf);
        vec_t v;
        v.name = name; v.stream = s; v.tgt = tgt; v.last_with_done = lwd;
        v.p1 = e1; v.p2 = e2; v.rc = erc; v.lc = elc; v.bad = ebad; v.ovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = 1'b0; dn = 1'b0; val = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit v, input bit d);
        int n = 0;
        @(negedge clk);
        val = b; vld = v; dn = d;
        while (!rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: ready low for %0d cycles, expected high", n);
            vld = 1'b0; dn = 1'b0;
            return;
        end
        @(posedge clk);
        #1 vld = 1'b0; dn = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, 1'b0);
    endtask

    task automatic finish_and_check(input string nm, input int e1, input int e2, input int erc,
                                    input int elc, input int ebad, input int eovf);
        int n = 0;
        while (!odv && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_valid"}, longint'(odv), 1);
        check({nm, "_p1"},   longint'(p1),  e1);
        check({nm, "_p2"},   longint'(p2),  e2);
        check({nm, "_rules"}, longint'(rc), erc);
        check({nm, "_lines"}, longint'(lc), elc);
        check({nm, "_bad"},  longint'(bad), ebad);
        check({nm, "_ovf"},  longint'(ovf), eovf);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        tsel = v.tgt;
        do_reset();
        n = v.stream.len();
        if (v.last_with_done) begin
            for (int i = 0; i < n - 1; i++) send(v.stream[i], 1'b1, 1'b0);
            send(v.stream[n-1], 1'b1, 1'b1);
        end else begin
            send_str(v.stream);
            send(8'h00, 1'b0, 1'b1);
        end
        finish_and_check(v.name, v.p1, v.p2, v.rc, v.lc, v.bad, v.ovf);
    endtask

    task automatic run_random(input int it);
        int    pg[8];
        bit    used[256];
        int    rx[$], ry[$];
        string s;
        int    e1, e2, elc, ebad;
        bit    no_nl;
        e1 = 0; e2 = 0; elc = 0; ebad = 0; s = "";
        for (int i = 0; i < 256; i++) begin
            used[i] = 1'b0;
            for (int j = 0; j < 256; j++) bef[i][j] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            int c;
            do c = int'($urandom_range(250, 10)); while (used[c]);
            used[c] = 1'b1;
            pg[i] = c;
        end
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++) begin
                rx.push_back(pg[i]); ry.push_back(pg[j]);
                bef[pg[i]][pg[j]] = 1'b1;
            end
        for (int k = rx.size() - 1; k > 0; k--) begin
            int r, t;
            r = int'($urandom_range(k, 0));
            t = rx[k]; rx[k] = rx[r]; rx[r] = t;
            t = ry[k]; ry[k] = ry[r]; ry[r] = t;
        end
        foreach (rx[k]) s = {s, $sformatf("%0d|%0d\n", rx[k], ry[k])};
        s = {s, "\n"};
        no_nl = $urandom_range(1, 0) == 1;
        for (int ln = 0; ln < 8; ln++) begin
            int pool[$], line[$], srt[$];
            int n, t;
            bit dup, ordered;
            n = int'($urandom_range(7, 1));
            for (int i = 0; i < 8; i++) pool.push_back(pg[i]);
            for (int k = 7; k > 0; k--) begin
                int r;
                r = int'($urandom_range(k, 0));
                t = pool[k]; pool[k] = pool[r]; pool[r] = t;
            end
            for (int i = 0; i < n; i++) line.push_back(pool[i]);
            dup = (n >= 2) && ($urandom_range(4, 0) == 0);
            if (dup) line[n-1] = line[0];
            if ($urandom_range(3, 0) == 0) s = {s, "\n"};
            for (int k = 0; k < n; k++) s = {s, $sformatf("%0d%s", line[k], (k < n - 1) ? "," : "")};
            if (!(ln == 7 && no_nl)) s = {s, "\n"};
            elc++;
            if (dup) ebad++;
            else begin
                srt = line;
                for (int p = 0; p < n; p++)
                    for (int k = 0; k < n - 1; k++)
                        if (bef[srt[k+1]][srt[k]]) begin
                            t = srt[k]; srt[k] = srt[k+1]; srt[k+1] = t;
                        end
                ordered = 1'b1;
                for (int k = 0; k < n; k++) if (srt[k] != line[k]) ordered = 1'b0;
                if (ordered) e1 += srt[n/2];
                else         e2 += srt[n/2];
            end
        end
        tsel = 1'b0;
        do_reset();
        send_str(s);
        send(8'h00, 1'b0, 1'b1);
        finish_and_check($sformatf("rand%0d", it), e1, e2, 28, elc, ebad, 0);
    endtask

    initial begin
        string ovs;
        int    cnt;
        ovs = "1|2\n\n";
        for (int i = 1; i <= 33; i++) ovs = {ovs, $sformatf("%0d%s", i, (i == 33) ? "\n" : ",")};

        add_vec("example",     {ex_rules, ex_lines},               0, 0, 143, 123, 21, 6, 0, 0);
        add_vec("broken",      "1|2\n\n2,1,3\n",                   0, 0, 0, 2, 1, 1, 0, 0);
        add_vec("dup",         "1|2\n\n5,5,7\n",                   0, 0, 0, 0, 1, 1, 1, 0);
        add_vec("partial",     {ex_rules, ex_lines, "75,47,61"},   0, 1, 190, 123, 21, 7, 0, 0);
        add_vec("rules_only",  "1|2\n3|4\n",                       0, 0, 0, 0, 2, 0, 0, 0);
        add_vec("too_long",    ovs,                                0, 0, 0, 0, 1, 1, 1, 1);
        add_vec("wrap",        "1|44\n\n300,1,9\n",                0, 0, 0, 44, 1, 1, 0, 0);
        add_vec("byte_done",   "1|2\n\n3,4,5,6",                   0, 1, 5, 0, 1, 1, 0, 0);
        add_vec("table_full",  "1|2\n3|4\n2|1\n\n2,1,3\n",         1, 0, 0, 2, 2, 1, 0, 1);
        add_vec("even_blank",  "3|5\n\n\n5,3\n\n",                 0, 0, 0, 5, 1, 1, 0, 0);
        add_vec("inconsist",   "2|1\n3|1\n1|3\n2|3\n\n1,2,3\n",    0, 0, 0, 0, 4, 1, 1, 0);

        tsel = 1'b0;
        do_reset();
        @(negedge clk);
        check("rst_ready", longint'(rdy), 1);
        check("rst_valid", longint'(odv), 0);
        check("rst_p1",    longint'(p1), 0);
        check("rst_rules", longint'(rc), 0);
        check("rst_lines", longint'(lc), 0);
        check("rst_ovf",   longint'(ovf), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        tsel = 1'b0;
        do_reset();
        send_str("1|2\n\n2,1,3");
        send("\n", 1'b1, 1'b0);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rdy || cnt > 200) break;
            cnt++;
        end
        check("busy_cycles", cnt, 7);
        send(8'h00, 1'b0, 1'b1);
        finish_and_check("busy", 0, 2, 1, 1, 0, 0);

        do_reset();
        send_str(ex_rules);
        send_str("75,47,61,53,29\n");
        repeat (4) @(negedge clk);
        check("midscan_busy", longint'(rdy), 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midscan_rst_ready", longint'(rdy), 1);
        check("midscan_rst_rules", longint'(rc), 0);
        send_str({ex_rules, ex_lines});
        send(8'h00, 1'b0, 1'b1);
        finish_and_check("replay", 143, 123, 21, 6, 0, 0);

        for (int it = 0; it < 3; it++) run_random(it);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
